enigma_step_ctrl: RTL and testbench
===================================

ENIGMA_STEP_CTRL -- requirements
Module: enigma_step_ctrl

Interface
REQ-001 Parameter: PATH_LAT, 3, cycles from path_launch edge to path_out valid; legal 1..15.
REQ-002 signal  in  1  clock, all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 mode  in  1  0 = encrypt, 1 = set rotors.
REQ-005 set_pos1, set_pos2, set_pos3  in  5 each  rotor start positions, legal 1..26.
REQ-006 key_in  in  5  plaintext letter, legal 1..26.
REQ-007 key_valid  in  1  key_in valid.
REQ-008 key_ready  out  1  controller can accept a key.
REQ-009 rot1_pos, rot2_pos, rot3_pos  out  5 each  current rotor positions, 1..26.
REQ-010 path_in  out  5  letter driven to rotor chain.
REQ-011 path_launch  out  1  one-cycle launch strobe to rotor chain.
REQ-012 path_out  in  5  letter returned by rotor chain.
REQ-013 ct_out  out  5  ciphertext letter.
REQ-014 ct_valid  out  1  ct_out valid.
REQ-015 ct_ready  in  1  consumer accepts ct_out.
REQ-016 key_count  out  6  accepted legal keys, modulo 52.
REQ-017 error  out  1  sticky illegal-value flag.

Function
REQ-018 FSM states: IDLE, STEP, LAUNCH, WAIT, HOLD; IDLE is only state accepting keys or settings.
REQ-019 key_ready = (state == IDLE) and mode == 0, combinational.
REQ-020 IDLE, mode 1: each edge loads rot1..3_pos from set_pos1..3 and clears key_count; any set_pos outside 1..26 -> no load of any rotor, error set.
REQ-021 IDLE, mode 0, key_valid and key_in in 1..26: capture key_in, go STEP.
REQ-022 IDLE, mode 0, key_valid and key_in 0 or 27..31: key consumed, error set, no step, stay IDLE.
REQ-023 STEP (one cycle): rot1_pos +1; rot1 26 -> 1 carries +1 to rot2; rot2 26 -> 1 with carry carries to rot3; rot3 26 -> 1 with carry, no further effect; key_count +1, 51 -> 0; go LAUNCH.
REQ-024 LAUNCH (one cycle): path_in = captured key, path_launch = 1; go WAIT.
REQ-025 path_in holds captured key from LAUNCH until next accept; path_launch = 0 in all other states.
REQ-026 WAIT lasts exactly PATH_LAT cycles; on its last edge ct_out <= path_out, ct_valid <= 1, go HOLD.
REQ-027 Latency: ct_valid rises on rising edge PATH_LAT+2 after accepting edge (5 edges for PATH_LAT = 3).
REQ-028 HOLD: ct_out, ct_valid stable until ct_ready = 1 at an edge; that edge clears ct_valid, go IDLE.
REQ-029 ct_ready = 1 while ct_valid already high: transfer on first edge in HOLD; minimum key-to-key spacing PATH_LAT+4 cycles.
REQ-030 mode, set_pos*, key_valid ignored outside IDLE; mode change mid-operation does not abort keystroke.
REQ-031 path_out value 0 or >26 at capture: captured as is, error set.
REQ-032 error cleared only by reset.

Reset
REQ-033 rst_n low: immediately state IDLE, rot1..3_pos = 1, key_count = 0, ct_out = 0, ct_valid = 0, path_in = 0, path_launch = 0, error = 0, WAIT counter = 0.
REQ-034 rst_n low mid-keystroke: keystroke discarded, no ct_valid after release.
REQ-035 First active edge after rst_n rises proceeds per IDLE rules.

Verification
REQ-036 mode 1, set 5/10/15, mode 0, key 1, path_out 7 -> positions 6/10/15, one path_launch with path_in 1, ct_out 7 at edge 5, key_count 1.
REQ-037 Set 26/26/26, one key -> positions 1/1/1 after STEP; set 26/3/4 -> 1/4/4.
REQ-038 52 legal keys from reset, ct_ready held 1 -> key_count returns to 0, rot1 = 1, rot2 = 3, rot3 = 1.
REQ-039 key_in 0 in IDLE -> error 1, positions unchanged, no path_launch; set_pos2 = 27 in mode 1 -> no rotor loaded, error 1.
REQ-040 ct_ready low 10 cycles in HOLD -> ct_valid, ct_out stable, key_ready 0, key_valid ignored; ct_ready high -> IDLE next edge.
REQ-041 rst_n low during WAIT -> all outputs at reset values asynchronously, positions 1/1/1, no ct_valid afterward.

Source files
------------

// File: rtl/enigma_step_ctrl.sv
// Enigma keystroke controller: rotor stepping, rotor-chain launch and
// ciphertext hand-off with a fixed-latency return path.
`timescale 1ns/1ps
module enigma_step_ctrl #(
    parameter int unsigned PATH_LAT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_i,
    input  logic [4:0] set_pos1_i,
    input  logic [4:0] set_pos2_i,
    input  logic [4:0] set_pos3_i,
    input  logic [4:0] key_in_i,
    input  logic       key_valid_i,
    output logic       key_ready_o,
    output logic [4:0] rot1_pos_o,
    output logic [4:0] rot2_pos_o,
    output logic [4:0] rot3_pos_o,
    output logic [4:0] path_in_o,
    output logic       path_launch_o,
    input  logic [4:0] path_out_i,
    output logic [4:0] ct_out_o,
    output logic       ct_valid_o,
    input  logic       ct_ready_i,
    output logic [5:0] key_count_o,
    output logic       error_o
);

    typedef enum logic [2:0] {
        IDLE, STEP, LAUNCH, WAIT, HOLD
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] rot1_q, rot1_d;
    logic [4:0] rot2_q, rot2_d;
    logic [4:0] rot3_q, rot3_d;
    logic [4:0] key_q, key_d;
    logic [4:0] pin_q, pin_d;
    logic [4:0] ct_q, ct_d;
    logic       ctv_q, ctv_d;
    logic [5:0] kcnt_q, kcnt_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    function automatic logic legal(input logic [4:0] v);
        return (v >= 5'd1) && (v <= 5'd26);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rot1_q  <= 5'd1;
            rot2_q  <= 5'd1;
            rot3_q  <= 5'd1;
            key_q   <= 5'd0;
            pin_q   <= 5'd0;
            ct_q    <= 5'd0;
            ctv_q   <= 1'b0;
            kcnt_q  <= 6'd0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rot1_q  <= rot1_d;
            rot2_q  <= rot2_d;
            rot3_q  <= rot3_d;
            key_q   <= key_d;
            pin_q   <= pin_d;
            ct_q    <= ct_d;
            ctv_q   <= ctv_d;
            kcnt_q  <= kcnt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rot1_d  = rot1_q;
        rot2_d  = rot2_q;
        rot3_d  = rot3_q;
        key_d   = key_q;
        pin_d   = pin_q;
        ct_d    = ct_q;
        ctv_d   = ctv_q;
        kcnt_d  = kcnt_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (mode_i) begin
                    kcnt_d = 6'd0;
                    if (legal(set_pos1_i) && legal(set_pos2_i) &&
                        legal(set_pos3_i)) begin
                        rot1_d = set_pos1_i;
                        rot2_d = set_pos2_i;
                        rot3_d = set_pos3_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (key_valid_i) begin
                    if (legal(key_in_i)) begin
                        key_d   = key_in_i;
                        state_d = STEP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STEP: begin
                // Odometer carry: rot2 moves only on rot1 wrap, rot3 on both
                if (rot1_q == 5'd26) begin
                    rot1_d = 5'd1;
                    if (rot2_q == 5'd26) begin
                        rot2_d = 5'd1;
                        rot3_d = (rot3_q == 5'd26) ? 5'd1 : rot3_q + 5'd1;
                    end else begin
                        rot2_d = rot2_q + 5'd1;
                    end
                end else begin
                    rot1_d = rot1_q + 5'd1;
                end
                kcnt_d  = (kcnt_q == 6'd51) ? 6'd0 : kcnt_q + 6'd1;
                pin_d   = key_q;
                state_d = LAUNCH;
            end
            LAUNCH: begin
                cnt_d   = 4'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'(PATH_LAT - 1)) begin
                    ct_d    = path_out_i;
                    ctv_d   = 1'b1;
                    state_d = HOLD;
                    if (!legal(path_out_i)) err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (ct_ready_i) begin
                    ctv_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_ready_o   = (state_q == IDLE) && !mode_i;
    assign path_launch_o = (state_q == LAUNCH);
    assign path_in_o     = pin_q;
    assign rot1_pos_o    = rot1_q;
    assign rot2_pos_o    = rot2_q;
    assign rot3_pos_o    = rot3_q;
    assign ct_out_o      = ct_q;
    assign ct_valid_o    = ctv_q;
    assign key_count_o   = kcnt_q;
    assign error_o       = err_q;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Directed bench for enigma_step_ctrl with hand-computed expectations.
`timescale 1ns/1ps
module tb_enigma_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic [4:0] sp1 = 5'd0, sp2 = 5'd0, sp3 = 5'd0;
    logic [4:0] key_in = 5'd0;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [4:0] r1, r2, r3;
    logic [4:0] path_in;
    logic       path_launch;
    logic [4:0] path_out = 5'd0;
    logic [4:0] ct_out;
    logic       ct_valid;
    logic       ct_ready = 1'b0;
    logic [5:0] key_count;
    logic       error;

    int vectors = 0;
    int miscompares = 0;
    int launches = 0;

    enigma_step_ctrl #(.PATH_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode),
        .set_pos1_i(sp1), .set_pos2_i(sp2), .set_pos3_i(sp3),
        .key_in_i(key_in), .key_valid_i(key_valid),
        .key_ready_o(key_ready),
        .rot1_pos_o(r1), .rot2_pos_o(r2), .rot3_pos_o(r3),
        .path_in_o(path_in), .path_launch_o(path_launch),
        .path_out_i(path_out),
        .ct_out_o(ct_out), .ct_valid_o(ct_valid), .ct_ready_i(ct_ready),
        .key_count_o(key_count), .error_o(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (path_launch) launches++;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int a, input int b,
                             input int c);
        check({tag, "_r1"}, int'(r1), a);
        check({tag, "_r2"}, int'(r2), b);
        check({tag, "_r3"}, int'(r3), c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mode = 1'b0; key_valid = 1'b0; ct_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_rotors(input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] c);
        mode = 1'b1; sp1 = a; sp2 = b; sp3 = c;
        @(negedge clk);
        mode = 1'b0;
    endtask

    task automatic run_key(input logic [4:0] k, input logic [4:0] po,
                           output int lat);
        int n;
        mode = 1'b0; key_in = k; key_valid = 1'b1;
        path_out = po; ct_ready = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        n = 0;
        while (!ct_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ct_valid) check("ct_valid_timeout", 0, 1);
        lat = n;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int l0;
        int seen;

        // Reset state
        #1;
        check("rst_ct_valid", int'(ct_valid), 0);
        check("rst_launch", int'(path_launch), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_pos("rst", 1, 1, 1);
        check("rst_kcnt", int'(key_count), 0);
        check("rst_ct_out", int'(ct_out), 0);
        check("rst_path_in", int'(path_in), 0);
        check("rst_error", int'(error), 0);
        check("rst_key_ready", int'(key_ready), 1);

        // Set 5/10/15, one key with path_out 7
        mode = 1'b1; sp1 = 5'd5; sp2 = 5'd10; sp3 = 5'd15;
        #1;
        check("set_key_ready", int'(key_ready), 0);
        @(negedge clk);
        mode = 1'b0;
        check_pos("set", 5, 10, 15);
        l0 = launches;
        key_in = 5'd1; key_valid = 1'b1; path_out = 5'd7; ct_ready = 1'b0;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            if (e == 0) begin
                key_valid = 1'b0;
                check("acc_key_ready", int'(key_ready), 0);
            end
            if (e == 1) begin
                check_pos("step", 6, 10, 15);
                check("step_kcnt", int'(key_count), 1);
                check("launch_hi", int'(path_launch), 1);
                check("launch_pin", int'(path_in), 1);
            end
            if (e == 2) check("launch_lo", int'(path_launch), 0);
            if (e == 4) check("edge4_ct_valid", int'(ct_valid), 0);
            if (e == 5) begin
                check("edge5_ct_valid", int'(ct_valid), 1);
                check("edge5_ct_out", int'(ct_out), 7);
            end
        end
        check("one_launch", launches - l0, 1);

        // HOLD stall with a key offered meanwhile
        key_in = 5'd3; key_valid = 1'b1; mode = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!ct_valid || ct_out != 5'd7 || key_ready) seen++;
        end
        check("hold_stable_bad_cycles", seen, 0);
        check("hold_path_in", int'(path_in), 1);
        key_valid = 1'b0; mode = 1'b0; ct_ready = 1'b1;
        @(negedge clk);
        ct_ready = 1'b0;
        check("release_ct_valid", int'(ct_valid), 0);
        check("release_key_ready", int'(key_ready), 1);
        check_pos("hold_ignored", 6, 10, 15);
        check("hold_one_launch", launches - l0, 1);

        // Full carry chain and single carry
        set_rotors(5'd26, 5'd26, 5'd26);
        run_key(5'd4, 5'd9, lat);
        check("latency", lat, 5);
        check_pos("wrap3", 1, 1, 1);
        set_rotors(5'd26, 5'd3, 5'd4);
        run_key(5'd26, 5'd26, lat);
        check_pos("wrap1", 1, 4, 4);
        check("wrap1_ct_out", int'(ct_out), 26);
        check("no_error_yet", int'(error), 0);

        // 52 keys from reset
        do_reset();
        for (int i = 1; i <= 52; i++) begin
            run_key(5'((i % 26) + 1), 5'd12, lat);
            if (i == 26) check_pos("k26", 1, 2, 1);
            if (i == 51) check("k51_kcnt", int'(key_count), 51);
        end
        check("k52_kcnt", int'(key_count), 0);
        check_pos("k52", 1, 3, 1);
        check("k52_ct_out", int'(ct_out), 12);

        // Illegal key
        do_reset();
        l0 = launches;
        key_in = 5'd0; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check("badkey_error", int'(error), 1);
        check("badkey_ready", int'(key_ready), 1);
        repeat (6) @(negedge clk);
        check("badkey_launch", launches - l0, 0);
        check_pos("badkey", 1, 1, 1);
        check("badkey_kcnt", int'(key_count), 0);

        // Illegal rotor setting
        do_reset();
        set_rotors(5'd5, 5'd10, 5'd15);
        check("goodset_error", int'(error), 0);
        set_rotors(5'd8, 5'd27, 5'd9);
        check_pos("badset", 5, 10, 15);
        check("badset_error", int'(error), 1);

        // Illegal path_out
        do_reset();
        run_key(5'd2, 5'd30, lat);
        check("badpath_ct_out", int'(ct_out), 30);
        check("badpath_error", int'(error), 1);

        // Reset during WAIT
        do_reset();
        set_rotors(5'd7, 5'd8, 5'd9);
        key_in = 5'd5; key_valid = 1'b1; path_out = 5'd11; ct_ready = 1'b1;
        repeat (3) @(negedge clk);
        key_valid = 1'b0;
        check("pre_rst_r1", int'(r1), 8);
        rst_n = 1'b0;
        #1;
        check_pos("async_rst", 1, 1, 1);
        check("async_rst_kcnt", int'(key_count), 0);
        check("async_rst_pin", int'(path_in), 0);
        check("async_rst_launch", int'(path_launch), 0);
        check("async_rst_ct_valid", int'(ct_valid), 0);
        check("async_rst_ct_out", int'(ct_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ct_valid) seen++;
        end
        check("post_rst_ct_valid", seen, 0);
        check("post_rst_key_ready", int'(key_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1);
    end

endmodule
